ex_muldiv_unit: RTL

- Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the decode controller and the ID/EX register.
- Consumes the EX-stage ALU control code and both operands.
- Holds the pipeline via a stall request while iterating, then presents a 32-bit result to the EX result mux for one completion cycle.
- Single-cycle ALU operations bypass this block entirely.

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/div_step.sv | 20 ++
 rtl/ex_muldiv_unit.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared core definitions: datapath width, EX ALU control codes and the
// multiply/divide sequencer state encoding.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_MUL = 4'b0010;
  localparam logic [3:0] ALU_DIV = 4'b0011;
  localparam logic [3:0] ALU_REM = 4'b1011;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } muldiv_state_e;

  function automatic logic is_muldiv_op(input logic [3:0] code);
    return (code == ALU_MUL) || (code == ALU_DIV) || (code == ALU_REM);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep it if non-negative.
module div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   rem_in,
  input  logic         dividend_bit,
  input  logic [W-1:0] divisor,
  output logic [W:0]   rem_out,
  output logic         q_bit
);

  logic [W+1:0] diff;

  // One extra bit above the shifted remainder so the MSB is a clean borrow flag.
  assign diff    = {rem_in, dividend_bit} - {2'b00, divisor};
  assign q_bit   = ~diff[W+1];
  assign rem_out = q_bit ? diff[W:0] : {rem_in[W-1:0], dividend_bit};

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M MUL/DIV/REM unit for the EX stage; stalls the pipe while
// iterating and presents the result for a single done cycle.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for an accepted MUL/DIV/REM
// CALC    | one shift-add or restoring-divide step per cycle
// FIX     | sign correction of quotient/remainder (pass-through for MUL)
// DONE    | result valid, done pulse, pipeline released
module ex_muldiv_unit #(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int ITER = XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [3:0]      alu_control_e,
  input  logic [XLEN-1:0] src_a_e,
  input  logic [XLEN-1:0] src_b_e,
  input  logic            flush_e,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            stall_req
);

  import riscv_pkg::*;

  localparam int CW = $clog2(ITER);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e state, state_nxt;

  logic [CW-1:0]   cnt;
  logic            op_mul, op_rem;
  logic            sign_a, sign_b;
  logic [XLEN-1:0] reg_a;   // multiplicand, or dividend shifting into quotient
  logic [XLEN-1:0] reg_b;   // multiplier, or divisor magnitude
  logic [XLEN:0]   acc;     // product low word, or partial remainder

  logic            accept, special, in_is_div;
  logic [XLEN-1:0] special_val, mag_a, mag_b, fix_val;
  logic            load_result;
  logic [XLEN-1:0] result_nxt;
  logic [XLEN:0]   rem_step;
  logic            q_step;

  assign accept    = start & ~flush_e & is_muldiv_op(alu_control_e);
  assign in_is_div = (alu_control_e == ALU_DIV);
  assign special   = (alu_control_e != ALU_MUL) &&
                     ((src_b_e == '0) || ((src_a_e == INT_MIN) && (src_b_e == '1)));

  always_comb begin
    special_val = '0;
    if (src_b_e == '0)
      special_val = in_is_div ? '1 : src_a_e;
    else
      special_val = in_is_div ? INT_MIN : '0;
  end

  assign mag_a = src_a_e[XLEN-1] ? (~src_a_e + 1'b1) : src_a_e;
  assign mag_b = src_b_e[XLEN-1] ? (~src_b_e + 1'b1) : src_b_e;

  div_step #(.W(XLEN)) u_div_step (
    .rem_in       (acc),
    .dividend_bit (reg_a[XLEN-1]),
    .divisor      (reg_b),
    .rem_out      (rem_step),
    .q_bit        (q_step)
  );

  always_comb begin
    fix_val = acc[XLEN-1:0];
    if (!op_mul) begin
      if (op_rem)
        fix_val = sign_a ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
      else
        fix_val = (sign_a ^ sign_b) ? (~reg_a + 1'b1) : reg_a;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MD_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    load_result = 1'b0;
    result_nxt  = result;
    case (state)
      MD_IDLE: begin
        if (accept) begin
          if (special) begin
            state_nxt   = MD_DONE;
            load_result = 1'b1;
            result_nxt  = special_val;
          end else begin
            state_nxt = MD_CALC;
          end
        end
      end
      MD_CALC: begin
        if (flush_e)         state_nxt = MD_IDLE;
        else if (cnt == '0)  state_nxt = MD_FIX;
      end
      MD_FIX: begin
        if (flush_e) begin
          state_nxt = MD_IDLE;
        end else begin
          state_nxt   = MD_DONE;
          load_result = 1'b1;
          result_nxt  = fix_val;
        end
      end
      MD_DONE: state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
  end

  assign busy      = (state == MD_CALC) || (state == MD_FIX);
  assign done      = (state == MD_DONE);
  assign stall_req = ((state == MD_IDLE) && accept) || busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      op_mul <= 1'b0;
      op_rem <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      reg_a  <= '0;
      reg_b  <= '0;
      acc    <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (accept && !special) begin
            cnt    <= CW'(ITER - 1);
            op_mul <= (alu_control_e == ALU_MUL);
            op_rem <= (alu_control_e == ALU_REM);
            acc    <= '0;
            if (alu_control_e == ALU_MUL) begin
              sign_a <= 1'b0;
              sign_b <= 1'b0;
              reg_a  <= src_a_e;
              reg_b  <= src_b_e;
            end else begin
              sign_a <= src_a_e[XLEN-1];
              sign_b <= src_b_e[XLEN-1];
              reg_a  <= mag_a;
              reg_b  <= mag_b;
            end
          end
        end
        MD_CALC: begin
          cnt <= cnt - 1'b1;
          if (op_mul) begin
            if (reg_b[0]) acc <= {1'b0, acc[XLEN-1:0] + reg_a};
            reg_a <= reg_a << 1;
            reg_b <= reg_b >> 1;
          end else begin
            acc   <= rem_step;
            reg_a <= {reg_a[XLEN-2:0], q_step};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           result <= '0;
    else if (load_result) result <= result_nxt;
  end

endmodule
